switch_cfg_writer: RTL
======================

Name: switch_cfg_writer

Overview:
- Consumes FMT_SWITCH_CFG packets already steered to this switch node and writes their entries into the switch routing table.
- Owns the table storage and provides the combinational (req, dest) match port that the route computation stage uses.
- Reports completion and error status per configuration packet.

Parameters:
- NODE, 5'd1, node_id_t of this switch; headers with any other dest are rejected.
- BUFFERS, 4, number of switch output buffers. OUT_W = $clog2(BUFFERS). Legal range 2..8.
- TABLE_ENTRIES, 32, number of routing table entries. IDX_W = $clog2(TABLE_ENTRIES). Legal range 2..256.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- flit_valid  in  1  config flit present.
- flit_ready  out  1  block accepts the flit this cycle.
- flit_payload  in  32  flit payload word.
- lookup_req  in  5  requester node id to match.
- lookup_dest  in  5  destination node id to match.
- lookup_hit  out  1  a valid entry matches.
- lookup_out_sel  out  OUT_W  output buffer of the matching entry; 0 on miss.
- cfg_done  out  1  one-cycle pulse when a packet finishes.
- cfg_err  out  1  qualified by cfg_done; packet had an error.
- cfg_count  out  7  qualified by cfg_done; number of entries written.
- busy  out  1  high while not in IDLE.

Behaviour:
- Flit transfer: a flit transfers when flit_valid && flit_ready. The sender holds payload stable until the transfer.
- Header flit fields: [31:28] format, [27:23] dest, [22:16] N = number of data flits. Other bits are reserved.
- Data flit fields: [31:24] index, [23:19] req, [18:14] dest, [13:11] out_sel (low OUT_W bits used), [10] valid. Other bits are reserved.
- Reset (async, n_rst=0):
  - all table entries invalid; state IDLE.
  - flit_ready=1; cfg_done=0, cfg_err=0, cfg_count=0; busy=0.
  - Reset asserted mid-packet discards the packet with no cfg_done pulse.
- FSM states: IDLE, DATA, COMMIT, DONE.
- IDLE: flit_ready=1. On a header transfer:
  - format != FMT_SWITCH_CFG or dest != NODE: go to DONE with err=1, count=0.
  - N == 0: go to DONE with err=0, count=0.
  - Otherwise latch N, clear remaining-count and error, go to DATA.
- DATA: flit_ready=1. Each data transfer decrements the remaining count.
  - index >= TABLE_ENTRIES: entry dropped, error set sticky.
  - Otherwise the entry {valid, req, dest, out_sel} is written and the written-count increments.
  - Transfer of the last data flit: go to COMMIT.
- COMMIT: flit_ready=0; one cycle; then DONE.
- DONE: flit_ready=0. cfg_done=1 for exactly this cycle, with cfg_err and cfg_count valid. Next state IDLE.
  - cfg_err and cfg_count read 0 whenever cfg_done=0.
- Write latency (without macro): an entry written by a data flit accepted at edge k is visible on the lookup port after edge k.
- Lookup: purely combinational, no pipeline.
  - Hit when entry.valid && entry.req == lookup_req && entry.dest == lookup_dest.
  - Multiple hits resolve to the lowest index.
- Two writes to the same index within one packet: the last one wins.
- valid=0 in a data flit invalidates that index and counts as written.
- Only the header flit is checked for format; data flit bits [31:28] are not checked.
- Minimum packet occupancy is N+3 cycles, counted from header acceptance through DONE.

Optional Feature:
- Macro: SWITCH_CFG_SHADOW_EN.
- Defined: DATA writes go to a shadow copy of the table.
  - On IDLE->DATA the shadow is loaded from the live table.
  - In COMMIT the shadow is copied to the live table only if the packet error is 0; otherwise it is discarded and cfg_count reports 0.
  - Lookups see no partial packet. New entries become visible after the COMMIT edge.
- Not defined: no shadow storage; writes are live per flit as above; COMMIT is an idle cycle.

Test Plan:
- Reset, then lookup req=2 dest=3 -> lookup_hit=0, lookup_out_sel=0; flit_ready=1; busy=0.
- Header {FMT_SWITCH_CFG, dest=1, N=2}, then data {idx=0, req=2, dest=3, sel=1, v=1} and {idx=5, req=4, dest=3, sel=2, v=1} -> cfg_done pulse, cfg_err=0, cfg_count=2; lookup (2,3) gives sel=1; lookup (4,3) gives sel=2.
- Header with dest=7 -> flit_ready low for exactly one cycle (DONE), cfg_done=1, cfg_err=1, cfg_count=0; table unchanged.
- N=3 with second data flit idx=40 (TABLE_ENTRIES=32) -> cfg_err=1, cfg_count=2 without macro; with SWITCH_CFG_SHADOW_EN, cfg_count=0 and the table is unchanged.
- idx=1 and idx=6 both programmed with (2,3), sel 1 and 3 -> lookup_out_sel=1 (lowest index wins). Rewrite idx=1 with v=0 -> sel=3.
- flit_valid toggling every other cycle during a 4-entry packet, with n_rst asserted after the 2nd data flit -> no cfg_done pulse; all entries invalid; state IDLE.

Source files
------------

// File: rtl/switch_cfg_writer.sv
// switch_cfg_writer: consumes FMT_SWITCH_CFG packets and programs the switch
// routing table. It also provides the combinational (req, dest) lookup port.
// Optional feature macro: SWITCH_CFG_SHADOW_EN. When it is defined, writes go
// to a shadow table, and the live table takes the shadow only when an
// error-free packet reaches COMMIT.
module switch_cfg_writer #(
  parameter logic [4:0] NODE           = 5'd1,
  parameter int         BUFFERS        = 4,
  parameter int         TABLE_ENTRIES  = 32,
  parameter logic [3:0] FMT_SWITCH_CFG = 4'h2,
  localparam int        OUT_W          = $clog2(BUFFERS),
  localparam int        IDX_W          = $clog2(TABLE_ENTRIES)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flit_valid,
  output logic             flit_ready,
  input  logic [31:0]      flit_payload,
  input  logic [4:0]       lookup_req,
  input  logic [4:0]       lookup_dest,
  output logic             lookup_hit,
  output logic [OUT_W-1:0] lookup_out_sel,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [6:0]       cfg_count,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_COMMIT, S_DONE} state_t;

  typedef struct packed {
    logic             v;
    logic [4:0]       req;
    logic [4:0]       dest;
    logic [OUT_W-1:0] sel;
  } entry_t;

  state_t     r_state, w_next;
  logic [6:0] r_remain, r_count;
  logic       r_err;
  entry_t     r_tbl [TABLE_ENTRIES];
`ifdef SWITCH_CFG_SHADOW_EN
  entry_t     r_shd [TABLE_ENTRIES];
`endif

  // Decoded flit fields. The header and data interpretations share the same
  // payload word; which one applies depends on the current state.
  logic             w_xfer, w_hdr_bad, w_idx_ok, w_wr, w_unused;
  logic [6:0]       w_hdr_n;
  logic [IDX_W-1:0] w_widx;
  entry_t           w_entry;

  assign w_xfer    = flit_valid && flit_ready;
  assign w_hdr_n   = flit_payload[22:16];
  assign w_hdr_bad = (flit_payload[31:28] != FMT_SWITCH_CFG) ||
                     (flit_payload[27:23] != NODE);
  assign w_idx_ok  = {1'b0, flit_payload[31:24]} < 9'(TABLE_ENTRIES);
  assign w_widx    = flit_payload[24 +: IDX_W];
  assign w_entry   = '{v:    flit_payload[10],
                       req:  flit_payload[23:19],
                       dest: flit_payload[18:14],
                       sel:  flit_payload[11 +: OUT_W]};
  assign w_wr      = (r_state == S_DATA) && w_xfer && w_idx_ok;
  // The reserved bits and the sel bits above OUT_W are ignored on purpose.
  assign w_unused  = ^{flit_payload[9:0], flit_payload[13:11]};

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and status outputs.
  // cfg_err and cfg_count are forced to zero outside the DONE cycle.
  always_comb begin
    w_next     = r_state;
    flit_ready = 1'b0;
    busy       = (r_state != S_IDLE);
    cfg_done   = 1'b0;
    cfg_err    = 1'b0;
    cfg_count  = 7'd0;
    case (r_state)
      S_IDLE: begin
        flit_ready = 1'b1;
        if (w_xfer) w_next = (w_hdr_bad || w_hdr_n == 7'd0) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        flit_ready = 1'b1;
        if (w_xfer && r_remain == 7'd1) w_next = S_COMMIT;
      end
      S_COMMIT: w_next = S_DONE;
      S_DONE: begin
        w_next   = S_IDLE;
        cfg_done = 1'b1;
        cfg_err  = r_err;
`ifdef SWITCH_CFG_SHADOW_EN
        // A discarded shadow means no entry was written.
        cfg_count = r_err ? 7'd0 : r_count;
`else
        cfg_count = r_count;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Packet bookkeeping: flits still to come, entries written, sticky error
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_remain <= 7'd0;
      r_count  <= 7'd0;
      r_err    <= 1'b0;
    end else if (w_xfer) begin
      if (r_state == S_IDLE) begin
        r_remain <= w_hdr_n;
        r_count  <= 7'd0;
        r_err    <= w_hdr_bad;
      end else if (r_state == S_DATA) begin
        r_remain <= r_remain - 7'd1;
        if (!w_idx_ok) r_err   <= 1'b1;
        else           r_count <= r_count + 7'd1;
      end
    end
  end

`ifdef SWITCH_CFG_SHADOW_EN
  // Table storage: the shadow is loaded at packet start and takes the data
  // writes. The live table copies it in COMMIT only when the packet is clean.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < TABLE_ENTRIES; i++) begin
        r_tbl[i] <= '0;
        r_shd[i] <= '0;
      end
    end else begin
      if (r_state == S_IDLE && w_next == S_DATA)
        for (int i = 0; i < TABLE_ENTRIES; i++) r_shd[i] <= r_tbl[i];
      if (w_wr) r_shd[w_widx] <= w_entry;
      if (r_state == S_COMMIT && !r_err)
        for (int i = 0; i < TABLE_ENTRIES; i++) r_tbl[i] <= r_shd[i];
    end
  end
`else
  // Table storage: each accepted data flit with an in-range index writes live
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < TABLE_ENTRIES; i++) r_tbl[i] <= '0;
    end else if (w_wr) begin
      r_tbl[w_widx] <= w_entry;
    end
  end
`endif

  // Lookup: the scan runs from high to low index so that the lowest-index hit
  // sets the final result
  always_comb begin
    lookup_hit     = 1'b0;
    lookup_out_sel = '0;
    for (int i = TABLE_ENTRIES - 1; i >= 0; i--) begin
      if (r_tbl[i].v && r_tbl[i].req == lookup_req && r_tbl[i].dest == lookup_dest) begin
        lookup_hit     = 1'b1;
        lookup_out_sel = r_tbl[i].sel;
      end
    end
  end

endmodule
